aes_inv_cipher: RTL and testbench
=================================

AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 The block SHALL have parameter Nk, default 4, meaning key length in 32-bit words; legal values 4, 6 and 8.
REQ-002 The block SHALL have parameter Nr, default Nk+6, meaning the number of rounds.
REQ-003 The block SHALL have port clk, input, width 1, meaning the clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1, meaning reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port start, input, width 1, meaning a request to decrypt cipherText.
REQ-006 The block SHALL have port cipherText, input, width [0:127], meaning the input block; bit 0 is the MSB of byte 0.
REQ-007 The block SHALL have port keys, input, width [0:128*(Nr+1)-1], meaning the expanded key schedule; round key r is keys[128*r +: 128], with r=0 first.
REQ-008 The block SHALL have port plainText, output reg, width [0:127], meaning the decrypted block.
REQ-009 The block SHALL have port busy, output, width 1, meaning a decryption is in progress.
REQ-010 The block SHALL have port done, output, width 1, meaning a single-cycle pulse that marks plainText valid.

Function
REQ-011 The block SHALL implement the FIPS-197 InvCipher, processing one round per clock, using the team's existing AddRoundKey, InvShiftRows, InvSubBytes and InvMixColumns leaf modules.
REQ-012 The FSM SHALL have states IDLE, INIT, ROUNDS and FINAL; the encoding is free.
REQ-013 IDLE with start=1 -> the block SHALL capture cipherText into the 128-bit state register and go to INIT; IDLE with start=0 -> it stays in IDLE.
REQ-014 INIT -> the block SHALL set state <= state XOR key[Nr] and round <= Nr-1, then go to ROUNDS.
REQ-015 ROUNDS -> the block SHALL set state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR key[round]) and decrement round; when round==1 at the edge, it goes to FINAL.
REQ-016 FINAL -> the block SHALL set plainText <= InvSubBytes(InvShiftRows(state)) XOR key[0], pulse done=1 for exactly the following cycle, and return to IDLE.
REQ-017 Latency SHALL be Nr+2 rising edges from the edge that samples start=1 to the edge that loads plainText; done SHALL be high in the cycle after that edge (12 edges for Nk=4, 14 for Nk=6, 16 for Nk=8).
REQ-018 The round counter SHALL be 4 bits wide and SHALL never underflow; key index selection SHALL use only values 0..Nr.
REQ-019 busy SHALL be 1 in INIT, ROUNDS and FINAL, and 0 in IDLE.
REQ-020 start while busy=1 SHALL be ignored, with no queuing and no effect on the running operation.
REQ-021 start in the same cycle that done=1 (FSM in IDLE) SHALL be accepted; back-to-back throughput is one block per Nr+2 cycles.
REQ-022 cipherText SHALL be sampled only at the start acceptance edge; later changes SHALL have no effect.
REQ-023 keys SHALL be held stable by the user from start acceptance through done; keys are not registered internally.
REQ-024 plainText SHALL hold its last value until the next FINAL edge.

Reset
REQ-025 On reset=1 the block SHALL immediately set state=IDLE, round=0, state register=0, plainText=0, done=0 and busy=0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL abort the block with no done pulse; the first start after deassertion SHALL behave as from power-up.
REQ-027 No output SHALL be X after the first reset assertion.

Verification
REQ-028 AES-128 check: keys = expansion of 000102030405060708090a0b0c0d0e0f, cipherText=69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> plainText=00112233445566778899aabbccddeeff, done 12 edges later.
REQ-029 AES-192 and AES-256 check: Nk=6, key 00..17, cipherText=dda97ca4864cdfe06eaf70a0ec0d7191 and Nk=8, key 00..1f, cipherText=8ea2b7ca516745bfeafc49904b496089 -> plainText=00112233445566778899aabbccddeeff, done 14 and 16 edges later respectively.
REQ-030 Start-while-busy check: a second start with a different cipherText at edge 5 -> exactly one done pulse and the first block's plaintext; busy stays 1 throughout.
REQ-031 Back-to-back check: start held high continuously with the AES-128 vector -> done pulses every 12 cycles, each with the correct plaintext.
REQ-032 Reset mid-operation check: reset asserted at edge 6 between clock edges -> outputs 0 immediately and no done pulse; a restart yields the correct result at the full latency.
REQ-033 Input-change check: cipherText changed to all-ones one cycle after start -> plainText is still the vector's expected value.

Source files
------------

// File: rtl/aes_inv_cipher.sv
// FIPS-197 AES inverse cipher, one round per clock, for 128/192/256-bit keys.
// The caller supplies the full expanded key schedule and holds it until done.

module AddRoundKey (
  input  logic [0:127] data_i,
  input  logic [0:127] key_i,
  output logic [0:127] data_o
);
  assign data_o = data_i ^ key_i;
endmodule

// Row r of the column-major state rotates right by r byte positions.
module InvShiftRows (
  input  logic [0:127] data_i,
  output logic [0:127] data_o
);
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
    assign data_o[8*gi +: 8] = data_i[8*SRC +: 8];
  end
endmodule

module InvSubBytes (
  input  logic [0:127] data_i,
  output logic [0:127] data_o
);
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{x, 3'b000} +: 8];
  endfunction

  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    assign data_o[8*gi +: 8] = inv_sbox(data_i[8*gi +: 8]);
  end
endmodule

module InvMixColumns (
  input  logic [0:127] data_i,
  output logic [0:127] data_o
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) product with a 4-bit constant (only 09, 0b, 0d, 0e are used).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] a2, a4, a8;
    a2 = xt(a);
    a4 = xt(a2);
    a8 = xt(a4);
    return (c[0] ? a : 8'h00) ^ (c[1] ? a2 : 8'h00) ^
           (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = data_i[32*gi      +: 8];
    assign a1 = data_i[32*gi + 8  +: 8];
    assign a2 = data_i[32*gi + 16 +: 8];
    assign a3 = data_i[32*gi + 24 +: 8];
    assign data_o[32*gi      +: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
    assign data_o[32*gi + 8  +: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
    assign data_o[32*gi + 16 +: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
    assign data_o[32*gi + 24 +: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
  end
endmodule

module aes_inv_cipher #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [0:127]          cipherText,
  input  logic [0:128*(Nr+1)-1] keys,
  output logic [0:127]          plainText,
  output logic                  busy,
  output logic                  done
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_INIT   = 2'd1;
  localparam logic [1:0] S_ROUNDS = 2'd2;
  localparam logic [1:0] S_FINAL  = 2'd3;
  localparam logic [3:0] LAST_ROUND = 4'(Nr);

  logic [1:0]   fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [0:127] state_q, state_d;
  logic [0:127] plain_d;
  logic         done_q, done_d;

  logic [0:127] round_keys [0:Nr];
  logic [3:0]   key_idx;
  logic [0:127] round_key, isr_out, isb_out, ark_in, ark_out, imc_out;

  for (genvar gi = 0; gi <= Nr; gi++) begin : g_rk
    assign round_keys[gi] = keys[128*gi +: 128];
  end

  always_comb begin
    key_idx = 4'd0;
    case (fsm_q)
      S_INIT:   key_idx = LAST_ROUND;
      S_ROUNDS: key_idx = round_q;
      default:  key_idx = 4'd0;
    endcase
  end

  assign round_key = (key_idx <= LAST_ROUND) ? round_keys[key_idx] : '0;

  // INIT whitens the raw state; every other busy state feeds the shifted, substituted state.
  assign ark_in = (fsm_q == S_INIT) ? state_q : isb_out;

  InvShiftRows u_isr (.data_i(state_q), .data_o(isr_out));
  InvSubBytes  u_isb (.data_i(isr_out), .data_o(isb_out));
  AddRoundKey  u_ark (.data_i(ark_in), .key_i(round_key), .data_o(ark_out));
  InvMixColumns u_imc (.data_i(ark_out), .data_o(imc_out));

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    plain_d = plainText;
    done_d  = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          state_d = cipherText;
          round_d = 4'd0;
          fsm_d   = S_INIT;
        end
      end
      S_INIT: begin
        state_d = ark_out;
        round_d = LAST_ROUND - 4'd1;
        fsm_d   = S_ROUNDS;
      end
      S_ROUNDS: begin
        state_d = imc_out;
        if (round_q != 4'd0) round_d = round_q - 4'd1;
        if (round_q <= 4'd1) fsm_d = S_FINAL;
      end
      default: begin
        plain_d = ark_out;
        done_d  = 1'b1;
        fsm_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q     <= S_IDLE;
      round_q   <= 4'd0;
      state_q   <= '0;
      plainText <= '0;
      done_q    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      round_q   <= round_d;
      state_q   <= state_d;
      plainText <= plain_d;
      done_q    <= done_d;
    end
  end

  assign busy = (fsm_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: three instances (AES-128/192/256) checked against an
// encrypt-side reference model, the FIPS-197 vectors, and control-path scenarios.

module tb_aes_inv_cipher;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start4, start6, start8;
  logic [0:127] ct4, ct6, ct8, pt4, pt6, pt8;
  logic busy4, busy6, busy8, done4, done6, done8;
  logic [0:1407] keys4;
  logic [0:1663] keys6;
  logic [0:1919] keys8;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sbox_t [256];
  localparam logic [0:127] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

  aes_inv_cipher #(.Nk(4)) dut4 (.clk(clk), .reset(reset), .start(start4), .cipherText(ct4),
    .keys(keys4), .plainText(pt4), .busy(busy4), .done(done4));
  aes_inv_cipher #(.Nk(6)) dut6 (.clk(clk), .reset(reset), .start(start6), .cipherText(ct6),
    .keys(keys6), .plainText(pt6), .busy(busy6), .done(done6));
  aes_inv_cipher #(.Nk(8)) dut8 (.clk(clk), .reset(reset), .start(start8), .cipherText(ct8),
    .keys(keys8), .plainText(pt8), .busy(busy8), .done(done8));

  // ---------------- reference model (forward cipher, from GF(2^8) arithmetic) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_t[a] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  function automatic logic [0:1919] expand_key(input logic [0:255] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [0:1919] ks;
    ks = '0;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      ks[32*i +: 32] = w[i];
    end
    return ks;
  endfunction

  function automatic logic [0:127] encrypt(input logic [0:127] blk, input logic [0:1919] ks, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [0:127] out;
    for (int i = 0; i < 16; i++) s[i] = blk[8*i +: 8] ^ ks[8*i +: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int i = 0; i < 16; i++) t[i] = s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[128*r + 8*i +: 8];
    end
    for (int i = 0; i < 16; i++) out[8*i +: 8] = s[i];
    return out;
  endfunction

  function automatic logic [0:255] seq_key(input int nk);
    logic [0:255] k;
    k = '0;
    for (int b = 0; b < 4 * nk; b++) k[8*b +: 8] = 8'(b);
    return k;
  endfunction

  // ---------------- drive / observe plumbing (no checking here) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int nk, input logic v, input logic [0:127] ct);
    case (nk)
      4:       begin start4 = v; ct4 = ct; end
      6:       begin start6 = v; ct6 = ct; end
      default: begin start8 = v; ct8 = ct; end
    endcase
  endtask

  task automatic set_keys(input int nk, input logic [0:1919] ks);
    case (nk)
      4:       keys4 = ks[0:1407];
      6:       keys6 = ks[0:1663];
      default: keys8 = ks;
    endcase
  endtask

  function automatic logic obs_done(input int nk);
    return (nk == 4) ? done4 : (nk == 6) ? done6 : done8;
  endfunction

  function automatic logic obs_busy(input int nk);
    return (nk == 4) ? busy4 : (nk == 6) ? busy6 : busy8;
  endfunction

  function automatic logic [0:127] obs_pt(input int nk);
    return (nk == 4) ? pt4 : (nk == 6) ? pt6 : pt8;
  endfunction

  task automatic launch(input int nk, input logic [0:127] ct);
    set_start(nk, 1'b1, ct);
    tick();
    set_start(nk, 1'b0, ct);
  endtask

  // Counts edges after the start-sampling edge until done is seen; budget+1 on timeout.
  task automatic wait_done(input int nk, input int budget, output int edges, output int busy_lows);
    busy_lows = 0;
    for (edges = 1; edges <= budget; edges++) begin
      tick();
      if (obs_done(nk)) return;
      if (!obs_busy(nk)) busy_lows++;
    end
  endtask

  // Nr+2 edges including the start edge, so done is visible Nr+1 edges after it.
  function automatic int exp_edges(input int nk);
    return nk + 7;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int nks [3] = '{4, 6, 8};
    reset = 1'b1;
    start4 = 0; start6 = 0; start8 = 0;
    ct4 = '0; ct6 = '0; ct8 = '0;
    keys4 = '0; keys6 = '0; keys8 = '0;
    #1;
    foreach (nks[i]) begin
      vectors++;
      if (obs_pt(nks[i]) !== 128'h0) begin miscompares++; $display("FAIL reset_pt nk=%0d got=%h want=0", nks[i], obs_pt(nks[i])); end
      vectors++;
      if (obs_busy(nks[i]) !== 1'b0) begin miscompares++; $display("FAIL reset_busy nk=%0d got=%b want=0", nks[i], obs_busy(nks[i])); end
      vectors++;
      if (obs_done(nks[i]) !== 1'b0) begin miscompares++; $display("FAIL reset_done nk=%0d got=%b want=0", nks[i], obs_done(nks[i])); end
    end
    $display("txn reset: outputs sampled during asynchronous reset");
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_fips();
    int nks [3] = '{4, 6, 8};
    logic [0:127] cts [3] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                              128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                              128'h8ea2b7ca516745bfeafc49904b496089};
    int edges, lows;
    foreach (nks[i]) begin
      set_keys(nks[i], expand_key(seq_key(nks[i]), nks[i]));
      launch(nks[i], cts[i]);
      wait_done(nks[i], 40, edges, lows);
      $display("txn fips nk=%0d ct=%h pt=%h edges=%0d", nks[i], cts[i], obs_pt(nks[i]), edges);
      vectors++;
      if (edges != exp_edges(nks[i])) begin miscompares++; $display("FAIL fips_latency nk=%0d got=%0d want=%0d", nks[i], edges, exp_edges(nks[i])); end
      vectors++;
      if (obs_pt(nks[i]) !== FIPS_PT) begin miscompares++; $display("FAIL fips_pt nk=%0d got=%h want=%h", nks[i], obs_pt(nks[i]), FIPS_PT); end
      vectors++;
      if (lows != 0) begin miscompares++; $display("FAIL fips_busy nk=%0d busy_low_cycles=%0d want=0", nks[i], lows); end
      tick();
    end
  endtask

  task automatic test_random();
    int nks [3] = '{4, 6, 8};
    int nk, edges, lows;
    logic [0:255] key;
    logic [0:127] pt, ct;
    logic [0:1919] ks;
    for (int n = 0; n < 12; n++) begin
      nk  = nks[n % 3];
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      ks  = expand_key(key, nk);
      ct  = encrypt(pt, ks, nk + 6);
      set_keys(nk, ks);
      launch(nk, ct);
      wait_done(nk, 40, edges, lows);
      $display("txn random nk=%0d ct=%h pt=%h edges=%0d", nk, ct, obs_pt(nk), edges);
      vectors++;
      if (obs_pt(nk) !== pt) begin miscompares++; $display("FAIL random_pt nk=%0d got=%h want=%h", nk, obs_pt(nk), pt); end
      vectors++;
      if (edges != exp_edges(nk)) begin miscompares++; $display("FAIL random_latency nk=%0d got=%0d want=%0d", nk, edges, exp_edges(nk)); end
    end
  endtask

  task automatic test_start_while_busy();
    int e, dones, first, lows;
    set_keys(4, expand_key(seq_key(4), 4));
    launch(4, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    e = 0; dones = 0; first = 0; lows = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); e++;
      if (!busy4) lows++;
    end
    set_start(4, 1'b1, ~128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    tick(); e++;
    if (!busy4) lows++;
    set_start(4, 1'b0, 128'h0);
    for (int k = 0; k < 40; k++) begin
      tick(); e++;
      if (done4) begin
        dones++;
        if (first == 0) first = e;
      end else if (first == 0 && !busy4) begin
        lows++;
      end
    end
    $display("txn start_while_busy dones=%0d first_done_edge=%0d pt=%h", dones, first, pt4);
    vectors++;
    if (dones != 1) begin miscompares++; $display("FAIL swb_done_count got=%0d want=1", dones); end
    vectors++;
    if (first != exp_edges(4)) begin miscompares++; $display("FAIL swb_latency got=%0d want=%0d", first, exp_edges(4)); end
    vectors++;
    if (pt4 !== FIPS_PT) begin miscompares++; $display("FAIL swb_pt got=%h want=%h", pt4, FIPS_PT); end
    vectors++;
    if (lows != 0) begin miscompares++; $display("FAIL swb_busy busy_low_cycles=%0d want=0", lows); end
  endtask

  task automatic test_back_to_back();
    logic [0:127] pts [4];
    logic [0:127] cts [4];
    logic [0:1919] ks;
    int edges, lows;
    ks = expand_key(seq_key(4), 4);
    set_keys(4, ks);
    pts[0] = FIPS_PT;
    cts[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    for (int b = 1; b < 4; b++) begin
      pts[b] = {$urandom, $urandom, $urandom, $urandom};
      cts[b] = encrypt(pts[b], ks, 10);
    end
    set_start(4, 1'b1, cts[0]);
    tick();
    for (int b = 0; b < 4; b++) begin
      wait_done(4, 40, edges, lows);
      // In the done cycle the FSM is idle, so the next block is accepted on the coming edge.
      if (b < 3) set_start(4, 1'b1, cts[b+1]);
      else set_start(4, 1'b0, cts[b]);
      $display("txn back_to_back blk=%0d pt=%h edges=%0d", b, pt4, edges);
      vectors++;
      if (pt4 !== pts[b]) begin miscompares++; $display("FAIL b2b_pt blk=%0d got=%h want=%h", b, pt4, pts[b]); end
      vectors++;
      if (edges != ((b == 0) ? exp_edges(4) : exp_edges(4) + 1)) begin
        miscompares++;
        $display("FAIL b2b_spacing blk=%0d got=%0d want=%0d", b, edges, (b == 0) ? exp_edges(4) : exp_edges(4) + 1);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int dones, edges, lows;
    set_keys(4, expand_key(seq_key(4), 4));
    launch(4, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    for (int k = 0; k < 5; k++) tick();
    #3;
    reset = 1'b1;
    #1;
    $display("txn reset_mid pt=%h busy=%b done=%b", pt4, busy4, done4);
    vectors++;
    if (pt4 !== 128'h0) begin miscompares++; $display("FAIL rmid_pt got=%h want=0", pt4); end
    vectors++;
    if (busy4 !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got=%b want=0", busy4); end
    tick();
    tick();
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done4) dones++;
    end
    vectors++;
    if (dones != 0) begin miscompares++; $display("FAIL rmid_spurious_done got=%0d want=0", dones); end
    launch(4, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_done(4, 40, edges, lows);
    $display("txn reset_mid restart pt=%h edges=%0d", pt4, edges);
    vectors++;
    if (pt4 !== FIPS_PT) begin miscompares++; $display("FAIL rmid_restart_pt got=%h want=%h", pt4, FIPS_PT); end
    vectors++;
    if (edges != exp_edges(4)) begin miscompares++; $display("FAIL rmid_restart_latency got=%0d want=%0d", edges, exp_edges(4)); end
  endtask

  task automatic test_input_change();
    int edges, lows;
    set_keys(8, expand_key(seq_key(8), 8));
    launch(8, 128'h8ea2b7ca516745bfeafc49904b496089);
    ct8 = '1;
    wait_done(8, 40, edges, lows);
    $display("txn input_change pt=%h edges=%0d", pt8, edges);
    vectors++;
    if (pt8 !== FIPS_PT) begin miscompares++; $display("FAIL inchg_pt got=%h want=%h", pt8, FIPS_PT); end
    vectors++;
    if (edges != exp_edges(8)) begin miscompares++; $display("FAIL inchg_latency got=%0d want=%0d", edges, exp_edges(8)); end
    for (int k = 0; k < 6; k++) begin
      ct8 = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    $display("txn hold pt=%h busy=%b", pt8, busy8);
    vectors++;
    if (pt8 !== FIPS_PT) begin miscompares++; $display("FAIL hold_pt got=%h want=%h", pt8, FIPS_PT); end
    vectors++;
    if (busy8 !== 1'b0) begin miscompares++; $display("FAIL hold_busy got=%b want=0", busy8); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_input_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
